// File: rtl/pipeline_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and helpers for the pipeline hazard controller.
//   fwd_sel_e       E-stage operand source select (RF / W result / M ALUResult)
//   mem_state_e     data-memory wait FSM states
//   RESULT_SRC_LOAD ResultSrc encoding of a load
//   reg_hit()       true when a writing stage targets a given non-zero source reg
package pipe_ctrl_pkg;
   typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_W = 2'b01, FWD_M = 2'b10} fwd_sel_e;
   typedef enum logic [1:0] {M_IDLE, M_WAIT, M_ERR} mem_state_e;
   localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;
   function automatic logic reg_hit(input logic we, input logic [4:0] rd, input logic [4:0] rs);
      return we && rd != 5'd0 && rd == rs;
   endfunction
endpackage

// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: hazard-control bundle between the datapath and pipeline_ctrl.
//   datapath -> ctrl : rs1_d, rs2_d, rs1_e, rs2_e, rd_e, ResultSrc_e, PCSrc_e,
//                      rd_m, RegWrite_m, mem_req_m, dmem_ready, rd_w, RegWrite_w
//   ctrl -> datapath : stall_f, stall_d, flush_d, stall_e, flush_e, enable_m,
//                      enable_w, clear_w, ForwardA_e, ForwardB_e, mem_timeout,
//                      stall_cnt, flush_cnt
//   master = controller side, slave = datapath side.
interface pipeline_ctrl_if #(parameter int CNT_W = 32);
   import pipe_ctrl_pkg::*;
   logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
   logic [1:0] ResultSrc_e;
   logic PCSrc_e, RegWrite_m, mem_req_m, dmem_ready, RegWrite_w;
   logic stall_f, stall_d, flush_d, stall_e, flush_e, enable_m, enable_w, clear_w;
   fwd_sel_e ForwardA_e, ForwardB_e;
   logic mem_timeout;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;
   modport master (
      input rs1_d, rs2_d, rs1_e, rs2_e, rd_e, ResultSrc_e, PCSrc_e, rd_m, RegWrite_m,
            mem_req_m, dmem_ready, rd_w, RegWrite_w,
      output stall_f, stall_d, flush_d, stall_e, flush_e, enable_m, enable_w, clear_w,
             ForwardA_e, ForwardB_e, mem_timeout, stall_cnt, flush_cnt
   );
   modport slave (
      output rs1_d, rs2_d, rs1_e, rs2_e, rd_e, ResultSrc_e, PCSrc_e, rd_m, RegWrite_m,
             mem_req_m, dmem_ready, rd_w, RegWrite_w,
      input stall_f, stall_d, flush_d, stall_e, flush_e, enable_m, enable_w, clear_w,
            ForwardA_e, ForwardB_e, mem_timeout, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/pipeline_ctrl_forward_unit.sv
// forward_unit: picks the E-stage source for one operand; M beats W beats RF.
//   rs_e                   source register in E
//   rd_m, regwrite_m       M-stage destination and write enable
//   rd_w, regwrite_w       W-stage destination and write enable
//   fwd                    selected source
module forward_unit
   import pipe_ctrl_pkg::*;
(
   input  logic [4:0] rs_e,
   input  logic [4:0] rd_m,
   input  logic       regwrite_m,
   input  logic [4:0] rd_w,
   input  logic       regwrite_w,
   output fwd_sel_e   fwd
);
   assign fwd = reg_hit(regwrite_m, rd_m, rs_e) ? FWD_M :
                reg_hit(regwrite_w, rd_w, rs_e) ? FWD_W : FWD_RF;
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard/sequencing controller for the 5-stage RV32I pipeline.
//   clk, rst_n   clock and synchronous active-low reset
//   bus          pipeline_ctrl_if master: hazard inputs in, stall/flush/enable/clear,
//                forwarding selects, sticky mem_timeout and saturating counters out
// MEM_TIMEOUT bounds how long a data-memory wait may hold the pipe; CNT_W sizes the counters.
module pipeline_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
)(
   input logic clk,
   input logic rst_n,
   pipeline_ctrl_if.master bus
);
   localparam int WC_W = $clog2(MEM_TIMEOUT) + 1;
   mem_state_e state, state_nx;
   logic [WC_W-1:0] wcnt, wcnt_nx;
   logic to_hit, mem_stall, lw_stall, lw_eff, flush_br, timeout_q;
   logic [CNT_W-1:0] stall_q, flush_q;
   fwd_sel_e fwd_a, fwd_b;

   forward_unit u_fwd_a (.rs_e(bus.rs1_e), .rd_m(bus.rd_m), .regwrite_m(bus.RegWrite_m),
                         .rd_w(bus.rd_w), .regwrite_w(bus.RegWrite_w), .fwd(fwd_a));
   forward_unit u_fwd_b (.rs_e(bus.rs2_e), .rd_m(bus.rd_m), .regwrite_m(bus.RegWrite_m),
                         .rd_w(bus.rd_w), .regwrite_w(bus.RegWrite_w), .fwd(fwd_b));

   assign to_hit = wcnt == WC_W'(MEM_TIMEOUT - 1);

   always_comb begin
      state_nx = state;
      wcnt_nx  = wcnt;
      case (state)
         M_IDLE: if (bus.mem_req_m && !bus.dmem_ready) begin
            state_nx = M_WAIT;
            wcnt_nx  = WC_W'(1);
         end
         M_WAIT: begin
            state_nx = bus.dmem_ready ? M_IDLE : to_hit ? M_ERR : M_WAIT;
            wcnt_nx  = (bus.dmem_ready || to_hit) ? '0 : wcnt + WC_W'(1);
         end
         default: state_nx = M_IDLE;
      endcase
   end

   // Every hazard term is qualified by rst_n so the pipe runs freely while held in reset.
   always_comb begin
      mem_stall = rst_n && ((state == M_IDLE && bus.mem_req_m && !bus.dmem_ready) ||
                            (state == M_WAIT && !bus.dmem_ready && !to_hit));
      lw_stall  = rst_n && !mem_stall && bus.ResultSrc_e == RESULT_SRC_LOAD && bus.rd_e != 5'd0 &&
                  (bus.rd_e == bus.rs1_d || bus.rd_e == bus.rs2_d);
      flush_br  = rst_n && !mem_stall && bus.PCSrc_e;
      // A taken branch discards the dependent instruction in D, so the load-use stall is moot.
      lw_eff    = lw_stall && !flush_br;
   end

   assign bus.stall_f     = mem_stall || lw_eff;
   assign bus.stall_d     = mem_stall || lw_eff;
   assign bus.stall_e     = mem_stall;
   assign bus.flush_d     = flush_br;
   assign bus.flush_e     = flush_br || lw_stall;
   assign bus.enable_m    = !mem_stall;
   assign bus.enable_w    = !mem_stall;
   assign bus.clear_w     = rst_n && state == M_ERR;
   assign bus.ForwardA_e  = rst_n ? fwd_a : FWD_RF;
   assign bus.ForwardB_e  = rst_n ? fwd_b : FWD_RF;
   assign bus.mem_timeout = timeout_q;
   assign bus.stall_cnt   = stall_q;
   assign bus.flush_cnt   = flush_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= M_IDLE;
         wcnt      <= '0;
         timeout_q <= 1'b0;
         stall_q   <= '0;
         flush_q   <= '0;
      end else begin
         state <= state_nx;
         wcnt  <= wcnt_nx;
         if (state == M_ERR) timeout_q <= 1'b1;
         if ((mem_stall || lw_eff) && !(&stall_q)) stall_q <= stall_q + CNT_W'(1);
         if (flush_br && !(&flush_q)) flush_q <= flush_q + CNT_W'(1);
      end
   end
endmodule
